// File: rtl/router_pkg.sv
// Shared types and header field positions for the router output-port reader.
// Imported by the reader top and its output buffer.
package router_pkg;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int MAX_LEN      = 63;

  typedef enum logic [1:0] {
    IDLE,
    PAY,
    PAR
  } rd_state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } rd_beat_t;

endpackage

// File: rtl/router_rd_buf.sv
// Two-entry valid/ready buffer of tagged beats with registered output.
// The writer must never push into a full buffer without a same-cycle pop.
module router_rd_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  rd_beat_t   in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output rd_beat_t   out_beat,
  output logic [1:0] occ
);

  rd_beat_t [1:0] mem_q, mem_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     occ_q, occ_d;
  logic           push, pop;

  assign out_valid = (occ_q != 2'd0);
  assign out_beat  = mem_q[rd_ptr_q];
  assign occ       = occ_q;

  // Next-state: write at tail, advance head on pop, flush clears pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    push     = in_valid & ~flush;
    pop      = out_valid & out_ready & ~flush;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_beat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Output-port drain engine: pops the FIFO, frames packets, checks parity,
// and drops a packet with a FIFO soft reset when the consumer stalls too long.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             empty,
  input  logic [7:0]       fifo_data,
  output logic             read_enb,
  output logic             soft_reset,
  output logic [7:0]       pkt_data,
  output logic             pkt_sop,
  output logic             pkt_eop,
  output logic             pkt_err,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [7:0]       err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_LEN + 1);

  rd_state_t        state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             pend_q, pend_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  rd_beat_t   cap_beat, out_beat;
  logic [1:0] occ;
  logic [2:0] lvl;
  logic       pop, stall, sr, cap;

  assign pop   = pkt_valid & pkt_ready;
  assign stall = (state_q != IDLE) & pkt_valid & ~pkt_ready;
  assign sr    = stall & (timer_q == TW'(TIMEOUT - 1));
  assign cap   = pend_q & ~sr;
  assign lvl   = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};

  // Buffer level after this cycle's capture and pop must leave room.
  assign read_enb   = ~reset & ~empty & ~sr & (lvl < 3'd2);
  assign pend_d     = read_enb;
  assign soft_reset = sr;

  assign pkt_data = out_beat.data;
  assign pkt_sop  = out_beat.sop;
  assign pkt_eop  = out_beat.eop;
  assign pkt_err  = out_beat.err;
  assign pkt_cnt  = pkt_cnt_q;
  assign err_cnt  = err_cnt_q;

  // Framing FSM: classify each captured byte and keep the counters.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;
    cap_beat      = '0;
    cap_beat.data = fifo_data;
    if (sr) begin
      state_d = IDLE;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (cap) begin
      unique case (state_q)
        IDLE: begin
          cap_beat.sop = 1'b1;
          acc_d        = fifo_data;
          rem_d        = fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];
          state_d      = (rem_d != '0) ? PAY : PAR;
        end
        PAY: begin
          acc_d = acc_q ^ fifo_data;
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = PAR;
        end
        PAR: begin
          cap_beat.eop = 1'b1;
          cap_beat.err = (fifo_data != acc_q);
          state_d      = IDLE;
          if (cap_beat.err) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stall timer: counts blocked mid-packet cycles, clears on progress.
  always_comb begin
    timer_d = timer_q;
    if (sr | pop | (state_q == IDLE)) timer_d = '0;
    else if (stall) timer_d = timer_q + TW'(1);
  end

  // State, accumulator, pending-read flag, timer and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 8'd0;
      rem_q     <= '0;
      pend_q    <= 1'b0;
      timer_q   <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  router_rd_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (sr),
    .in_valid  (cap),
    .in_beat   (cap_beat),
    .out_valid (pkt_valid),
    .out_ready (pkt_ready),
    .out_beat  (out_beat),
    .occ       (occ)
  );

endmodule
